// File: rtl/timer_counter_8bit.sv
// 8-bit up/down timer with reload, sticky wrap flags and an APB register port.
// Zero-wait-state APB (pready = psel & penable); the counter advances on rising edges of the selected clk_in level.
module timer_counter_8bit (
  input  logic       pclk,
  input  logic       preset_n,
  input  logic [3:0] clk_in,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [2:0] paddr,
  input  logic [7:0] pwdata,
  output logic [7:0] prdata,
  output logic       pready,
  output logic       pslverr,
  output logic       TMR_OVF,
  output logic       TMR_UDF
);

  typedef struct packed {
    logic       load;
    logic       dir;
    logic       en;
    logic [1:0] csel;
  } tcr_t;

  localparam logic [2:0] ADDR_TCNT = 3'd0;
  localparam logic [2:0] ADDR_TSR  = 3'd1;
  localparam logic [2:0] ADDR_TDR  = 3'd2;
  localparam logic [2:0] ADDR_TCR  = 3'd3;

  logic [7:0] tcnt;
  logic [7:0] tcnt_nxt;
  logic [7:0] tdr;
  logic [1:0] tsr;
  logic [1:0] tsr_clr;
  tcr_t       tcr;
  logic [3:0] clk_prev;
  logic [7:0] rd_mux;

  logic acc;
  logic wr_en;
  logic unmapped;
  logic tick;
  logic count_en;
  logic ovf_set;
  logic udf_set;

  assign acc      = psel & penable;
  assign unmapped = paddr[2];
  assign wr_en    = acc & pwrite & ~unmapped;

  // Outputs are forced low while reset is held, even with an active bus.
  assign pready  = acc & ~preset_n;
  assign pslverr = acc & unmapped & ~preset_n;

  // Every clk_in bit keeps its own history so re-selecting cannot fake an edge.
  assign tick     = clk_in[tcr.csel] & ~clk_prev[tcr.csel];
  assign count_en = ~tcr.load & tcr.en & tick;
  assign ovf_set  = count_en & ~tcr.dir & (tcnt == 8'hFF);
  assign udf_set  = count_en & tcr.dir & (tcnt == 8'h00);
  assign tsr_clr  = (wr_en && paddr == ADDR_TSR) ? ~pwdata[1:0] : 2'b00;

  always_comb begin
    tcnt_nxt = tcnt;
    if (tcr.load) begin
      tcnt_nxt = tdr;
    end else if (count_en) begin
      tcnt_nxt = tcr.dir ? (tcnt - 8'd1) : (tcnt + 8'd1);
    end
  end

  always_ff @(posedge pclk or posedge preset_n) begin
    if (preset_n) begin
      tcnt     <= 8'h00;
      tdr      <= 8'h00;
      tsr      <= 2'b00;
      tcr      <= '0;
      clk_prev <= 4'h0;
    end else begin
      tcnt     <= tcnt_nxt;
      clk_prev <= clk_in;
      // A wrap on the same edge as a software clear keeps the flag set.
      tsr      <= (tsr & ~tsr_clr) | {udf_set, ovf_set};
      if (wr_en && paddr == ADDR_TDR) begin
        tdr <= pwdata;
      end
      if (wr_en && paddr == ADDR_TCR) begin
        tcr <= {pwdata[7], pwdata[5:4], pwdata[1:0]};
      end
    end
  end

  always_comb begin
    rd_mux = 8'h00;
    case (paddr)
      ADDR_TCNT: rd_mux = tcnt;
      ADDR_TSR:  rd_mux = {6'd0, tsr};
      ADDR_TDR:  rd_mux = tdr;
      ADDR_TCR:  rd_mux = {tcr.load, 1'b0, tcr.dir, tcr.en, 2'b00, tcr.csel};
      default:   rd_mux = 8'h00;
    endcase
  end

  assign prdata  = (psel & ~pwrite & ~preset_n) ? rd_mux : 8'h00;
  assign TMR_OVF = tsr[0];
  assign TMR_UDF = tsr[1];

endmodule

// File: tb/tb_timer_counter_8bit.sv
// Bench for timer_counter_8bit: directed scenarios plus random traffic against a register-level model.
module tb_timer_counter_8bit;

  logic       pclk = 1'b0;
  logic       preset_n;
  logic [3:0] clk_in;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [2:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;
  logic       TMR_OVF;
  logic       TMR_UDF;

  timer_counter_8bit dut (
    .pclk(pclk), .preset_n(preset_n), .clk_in(clk_in),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslverr(pslverr),
    .TMR_OVF(TMR_OVF), .TMR_UDF(TMR_UDF)
  );

  always #5 pclk = ~pclk;

  int errors = 0;
  int checks = 0;

  // Register-level model of the timer
  int       m_tcnt, m_tdr, m_tcr;
  bit       m_ovf, m_udf;
  bit [3:0] m_prev;

  int         div_cnt = 0;
  bit         rand_clk = 0;
  logic [7:0] last_rd;
  logic       last_err, last_rdy;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_tcnt = 0; m_tdr = 0; m_tcr = 0; m_ovf = 0; m_udf = 0; m_prev = 4'h0;
  endtask

  function automatic logic [7:0] m_read(input logic [2:0] a);
    case (a)
      3'd0:    return 8'(m_tcnt);
      3'd1:    return {6'd0, m_udf, m_ovf};
      3'd2:    return 8'(m_tdr);
      3'd3:    return 8'(m_tcr);
      default: return 8'h00;
    endcase
  endfunction

  // Applies one rising edge to the model using the bus values currently driven.
  task automatic model_edge();
    logic [1:0] sel;
    bit tick, wr, so, su;
    int nt;
    sel  = 2'(m_tcr);
    tick = clk_in[sel] && !m_prev[sel];
    wr   = psel && penable && pwrite;
    nt   = m_tcnt;
    so   = 0;
    su   = 0;
    if ((m_tcr & 'h80) != 0) begin
      nt = m_tdr;
    end else if ((m_tcr & 'h10) != 0 && tick) begin
      if ((m_tcr & 'h20) != 0) begin
        su = (m_tcnt == 0);
        nt = (m_tcnt + 255) % 256;
      end else begin
        so = (m_tcnt == 255);
        nt = (m_tcnt + 1) % 256;
      end
    end
    if (wr && paddr == 3'd1) begin
      if (!pwdata[0]) m_ovf = 0;
      if (!pwdata[1]) m_udf = 0;
    end
    if (so) m_ovf = 1;
    if (su) m_udf = 1;
    if (wr && paddr == 3'd2) m_tdr = pwdata;
    if (wr && paddr == 3'd3) m_tcr = pwdata & 'hB3;
    m_tcnt = nt;
    m_prev = clk_in;
  endtask

  // One pclk cycle: drive just after an edge, check combinational outputs, then the edge, then flags.
  task automatic step(input bit s, input bit e, input bit w, input logic [2:0] a, input logic [7:0] d);
    logic [7:0] exp_rd;
    psel = s; penable = e; pwrite = w; paddr = a; pwdata = d;
    clk_in = rand_clk ? 4'($urandom) : div_cnt[3:0];
    div_cnt++;
    #2;
    exp_rd = (s && !w) ? m_read(a) : 8'h00;
    check_eq("prdata", prdata, exp_rd);
    check_eq("pready", {7'd0, pready}, {7'd0, s && e});
    check_eq("pslverr", {7'd0, pslverr}, {7'd0, s && e && (a > 3)});
    last_rd = prdata; last_err = pslverr; last_rdy = pready;
    @(posedge pclk);
    model_edge();
    #1;
    check_eq("tmr_ovf", {7'd0, TMR_OVF}, {7'd0, m_ovf});
    check_eq("tmr_udf", {7'd0, TMR_UDF}, {7'd0, m_udf});
  endtask

  task automatic peek();
    step(1, 0, 0, 3'd0, 8'h00);
  endtask

  task automatic apb_wr(input logic [2:0] a, input logic [7:0] d);
    step(1, 0, 1, a, d);
    step(1, 1, 1, a, d);
  endtask

  task automatic apb_rd(input logic [2:0] a);
    step(1, 0, 0, a, 8'h00);
    step(1, 1, 0, a, 8'h00);
  endtask

  task automatic wait_ovf(input int budget);
    for (int i = 0; i < budget && !TMR_OVF; i++) peek();
    check_eq("ovf_wait", {7'd0, TMR_OVF}, 8'h01);
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] seq_q[$];
    logic [7:0] seq_exp[4];
    int cyc, last_chg, nchg;

    // Reset state with an active bus access
    preset_n = 1; psel = 1; penable = 1; pwrite = 0; paddr = 3'd0; pwdata = 8'h00; clk_in = 4'h0;
    model_reset();
    #3;
    check_eq("rst_prdata", prdata, 8'h00);
    check_eq("rst_pready", {7'd0, pready}, 8'h00);
    check_eq("rst_pslverr", {7'd0, pslverr}, 8'h00);
    check_eq("rst_ovf", {7'd0, TMR_OVF}, 8'h00);
    check_eq("rst_udf", {7'd0, TMR_UDF}, 8'h00);
    @(posedge pclk); @(posedge pclk); #1;
    preset_n = 0;
    for (int i = 0; i < 4; i++) peek();

    // Load 0xF0, count up at pclk/8 until wrap
    apb_wr(3'd2, 8'hF0);
    apb_wr(3'd3, 8'h82);
    apb_rd(3'd0);
    check_eq("load_f0", last_rd, 8'hF0);
    apb_wr(3'd3, 8'h12);
    peek();
    v = last_rd;
    check_eq("start_f0", v, 8'hF0);
    cyc = 0; last_chg = -1; nchg = 0;
    for (int i = 0; i < 300 && !TMR_OVF; i++) begin
      peek();
      cyc++;
      if (last_rd != v) begin
        if (last_chg >= 0) check_eq("tick_period", 8'(cyc - last_chg), 8'd8);
        check_eq("tick_step", last_rd, v + 8'd1);
        last_chg = cyc; nchg++; v = last_rd;
      end
    end
    check_eq("ovf_set", {7'd0, TMR_OVF}, 8'h01);
    check_eq("ticks_before_wrap", 8'(nchg), 8'd15);
    peek();
    check_eq("wrap_zero", last_rd, 8'h00);

    // Clearing OVF, then clear racing a wrap
    apb_wr(3'd1, 8'h00);
    check_eq("ovf_cleared", {7'd0, TMR_OVF}, 8'h00);
    apb_wr(3'd2, 8'hFF);
    apb_wr(3'd3, 8'h80);
    apb_wr(3'd3, 8'h10);
    wait_ovf(20);
    apb_wr(3'd3, 8'h80);
    while (div_cnt[0]) peek();
    apb_wr(3'd3, 8'h10);
    apb_wr(3'd1, 8'h00);
    check_eq("set_wins", {7'd0, TMR_OVF}, 8'h01);
    peek();
    check_eq("set_wins_cnt", last_rd, 8'h00);

    // Down count at pclk/2 through underflow
    apb_wr(3'd2, 8'h02);
    apb_wr(3'd3, 8'h80);
    apb_wr(3'd3, 8'h30);
    peek();
    seq_q.push_back(last_rd);
    for (int i = 0; i < 20 && seq_q.size() < 4; i++) begin
      peek();
      if (last_rd != seq_q[$]) seq_q.push_back(last_rd);
    end
    seq_exp = '{8'h02, 8'h01, 8'h00, 8'hFF};
    check_eq("down_len", 8'(seq_q.size()), 8'd4);
    for (int i = 0; i < 4 && i < seq_q.size(); i++) check_eq("down_seq", seq_q[i], seq_exp[i]);
    check_eq("udf_set", {7'd0, TMR_UDF}, 8'h01);

    // Unmapped access and TCR reserved bits
    apb_wr(3'd5, 8'hFF);
    check_eq("err_wr", {7'd0, last_err}, 8'h01);
    check_eq("rdy_wr", {7'd0, last_rdy}, 8'h01);
    apb_rd(3'd2);
    check_eq("tdr_kept", last_rd, 8'h02);
    apb_rd(3'd6);
    check_eq("unmapped_rd", last_rd, 8'h00);
    apb_wr(3'd0, 8'h55);
    apb_wr(3'd3, 8'hFF);
    apb_rd(3'd3);
    check_eq("tcr_mask", last_rd, 8'hB3);
    apb_wr(3'd3, 8'h00);

    // Freeze on disable, then clock-select changes while running
    apb_wr(3'd2, 8'h10);
    apb_wr(3'd3, 8'h80);
    apb_wr(3'd3, 8'h10);
    for (int i = 0; i < 6; i++) peek();
    apb_wr(3'd3, 8'h02);
    peek();
    v = last_rd;
    for (int i = 0; i < 20; i++) peek();
    check_eq("frozen", last_rd, v);
    apb_wr(3'd3, 8'h10);
    for (int i = 0; i < 5; i++) peek();
    apb_wr(3'd3, 8'h11);
    for (int i = 0; i < 5; i++) peek();
    apb_wr(3'd3, 8'h13);
    for (int i = 0; i < 20; i++) peek();
    apb_wr(3'd3, 8'h10);
    for (int i = 0; i < 5; i++) peek();

    // Random traffic, alternating divider and random clk_in
    for (int i = 0; i < 1500; i++) begin
      int r;
      logic [2:0] a;
      logic [7:0] d;
      rand_clk = (i / 250) % 2 == 1;
      r = $urandom_range(0, 9);
      a = 3'($urandom);
      d = 8'($urandom);
      if (a == 3'd3 && $urandom_range(0, 3) != 0) d[7] = 1'b0;
      if (a == 3'd3 && $urandom_range(0, 1) != 0) d[4] = 1'b1;
      if (r < 3) apb_wr(a, d);
      else if (r < 5) apb_rd(a);
      else peek();
    end
    rand_clk = 0;

    // Asynchronous reset between edges while counting with flags set
    apb_wr(3'd2, 8'hFE);
    apb_wr(3'd3, 8'h80);
    apb_wr(3'd3, 8'h10);
    wait_ovf(20);
    for (int i = 0; i < 3; i++) peek();
    psel = 1; penable = 1; pwrite = 0; paddr = 3'd0;
    #2;
    preset_n = 1;
    #1;
    check_eq("arst_prdata", prdata, 8'h00);
    check_eq("arst_pready", {7'd0, pready}, 8'h00);
    check_eq("arst_ovf", {7'd0, TMR_OVF}, 8'h00);
    check_eq("arst_udf", {7'd0, TMR_UDF}, 8'h00);
    paddr = 3'd5;
    #1;
    check_eq("arst_pslverr", {7'd0, pslverr}, 8'h00);
    @(posedge pclk); @(posedge pclk); #1;
    preset_n = 0;
    model_reset();
    for (int i = 0; i < 40; i++) peek();
    check_eq("post_rst_hold", last_rd, 8'h00);
    apb_rd(3'd3);
    check_eq("post_rst_tcr", last_rd, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
